// File: rtl/accum_unit.sv
// Ternary-weight (+1/-1) spiking accumulator: counts enabled steps and emits a one-cycle
// registered trigger when the count reaches THRESHOLD. Define ACCUM_LEAK_EN to make idle cycles decay the count toward zero.
module accum_unit #(
  parameter int THRESHOLD = 31
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic prop_in,
  input  logic inc,
  output logic trigger
);

  localparam int W = $clog2(THRESHOLD + 1) + 1;

  localparam logic signed [W-1:0] CNT_ONE   = W'(1);
  localparam logic signed [W-1:0] CNT_FIRE  = W'(THRESHOLD - 1);
  localparam logic signed [W-1:0] CNT_FLOOR = W'(-THRESHOLD);

  logic signed [W-1:0] count_q, count_d;
  logic                trigger_q, trigger_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    count_d   = count_q;
    trigger_d = 1'b0;
    if (prop_in) begin
      if (inc) begin
        if (count_q == CNT_FIRE) begin
          count_d   = '0;
          trigger_d = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else if (count_q != CNT_FLOOR) begin
        count_d = count_q - CNT_ONE;
      end
    end
`ifdef ACCUM_LEAK_EN
    else if (count_q[W-1]) begin
      count_d = count_q + CNT_ONE;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_ONE;
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    // NOTE: reset is synchronous; it is sampled only on the clock edge and takes priority over all inputs.
    if (!rst_in) begin
      count_q   <= '0;
      trigger_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      count_q   <= count_d;
      trigger_q <= trigger_d;
    end
  end

  assign trigger = trigger_q;

endmodule

// File: tb/tb_accum_unit.sv
// Scoreboard bench for accum_unit: a THRESHOLD=31 and a THRESHOLD=1 instance share stimulus;
// an integer reference model queues expected triggers and a monitor compares them every cycle.
module tb_accum_unit;

  localparam int THR = 31;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic prop_in = 1'b0;
  logic inc = 1'b0;
  logic trigger;
  logic trigger1;

  accum_unit #(.THRESHOLD(THR)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .prop_in(prop_in),
    .inc    (inc),
    .trigger(trigger)
  );

  accum_unit #(.THRESHOLD(1)) dut1 (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .prop_in(prop_in),
    .inc    (inc),
    .trigger(trigger1)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic exp_a;
    logic exp_b;
    int   edge_no;
  } exp_t;

  exp_t sb_q[$];
  int   fire_edges[$];
  int   checks = 0;
  int   errors = 0;
  int   drv_edge = 0;
  int   m_a = 0;
  int   m_b = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: plain integer count, fire when it reaches thr, floor at -thr.
  task automatic model(inout int cnt, input int thr, input bit r, input bit p, input bit i,
                       output bit fire);
    fire = 1'b0;
    if (!r) begin
      cnt = 0;
    end else if (p) begin
      if (i) begin
        cnt++;
        if (cnt == thr) begin
          cnt  = 0;
          fire = 1'b1;
        end
      end else if (cnt > -thr) begin
        cnt--;
      end
    end else begin
`ifdef ACCUM_LEAK_EN
      if (cnt > 0) cnt--;
      else if (cnt < 0) cnt++;
`endif
    end
  endtask

  // One clock edge of stimulus; inputs change on the falling edge.
  task automatic step(input bit r, input bit p, input bit i);
    exp_t e;
    bit   fa, fb;
    @(negedge clk_in);
    rst_in  = r;
    prop_in = p;
    inc     = i;
    model(m_a, THR, r, p, i, fa);
    model(m_b, 1, r, p, i, fb);
    drv_edge++;
    e.exp_a   = fa;
    e.exp_b   = fb;
    e.edge_no = drv_edge;
    sb_q.push_back(e);
  endtask

  // An idle edge that also lets the monitor catch up on everything issued before it.
  task automatic settle();
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("trig_t31@%0d", e.edge_no), trigger, e.exp_a);
        check($sformatf("trig_t1@%0d", e.edge_no), trigger1, e.exp_b);
        if (trigger === 1'b1) fire_edges.push_back(e.edge_no);
      end
    end
  end

  function automatic int fires_between(input int lo, input int hi);
    int n = 0;
    foreach (fire_edges[k]) if (fire_edges[k] > lo && fire_edges[k] <= hi) n++;
    return n;
  endfunction

  function automatic int first_fire(input int lo);
    foreach (fire_edges[k]) if (fire_edges[k] > lo) return fire_edges[k] - lo;
    return -1;
  endfunction

  function automatic int min_gap(input int lo, input int hi);
    int g = 1 << 30;
    int prev = -1;
    foreach (fire_edges[k]) begin
      if (fire_edges[k] > lo && fire_edges[k] <= hi) begin
        if (prev >= 0 && fire_edges[k] - prev < g) g = fire_edges[k] - prev;
        prev = fire_edges[k];
      end
    end
    return g;
  endfunction

  initial begin
    int base;

    // Reset held with enable/inc high, then a straight run of increments.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    base = drv_edge;
    repeat (62) step(1'b1, 1'b1, 1'b1);
    settle();
    check("reset_no_fire", fires_between(0, base), 0);
    check("straight_first", first_fire(base), 31);
    check("straight_second", first_fire(base + 31), 31);
    check("straight_count", fires_between(base, base + 62), 2);

    // Mixed stream: 7 up, 3 down per 10 cycles.
    step(1'b0, 1'b0, 1'b0);
    base = drv_edge;
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, (i % 10) < 7);
    settle();
    check("mixed_first", first_fire(base), 67);
    check("mixed_count", fires_between(base, base + 1000), 13);
    check("mixed_gap_ok", min_gap(base, base + 1000) >= THR, 1);

    // Floor saturation then climb from -31.
    step(1'b0, 1'b0, 1'b0);
    base = drv_edge;
    repeat (40) step(1'b1, 1'b1, 1'b0);
    repeat (62) step(1'b1, 1'b1, 1'b1);
    settle();
    check("floor_count", fires_between(base, base + 102), 1);
    check("floor_edge", first_fire(base), 102);

    // Hold (or leak) across 20 idle cycles with inc toggling randomly.
    step(1'b0, 1'b0, 1'b0);
    base = drv_edge;
    repeat (10) step(1'b1, 1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    repeat (31) step(1'b1, 1'b1, 1'b1);
    settle();
    check("idle_count", fires_between(base, base + 61), 1);
`ifdef ACCUM_LEAK_EN
    check("idle_fire_edge", first_fire(base), 61);
`else
    check("idle_fire_edge", first_fire(base), 51);
`endif

    // Reset arriving at count 30 together with an increment.
    step(1'b0, 1'b0, 1'b0);
    base = drv_edge;
    repeat (30) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (31) step(1'b1, 1'b1, 1'b1);
    settle();
    check("midreset_count", fires_between(base, base + 62), 1);
    check("midreset_edge", first_fire(base), 62);

    // Random traffic with occasional resets, checked by the scoreboard alone.
    step(1'b0, 1'b0, 1'b0);
    repeat (3000) step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 9) < 7);
    settle();
    @(posedge clk_in);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
